// File: rtl/pattern_generator_param_pkg.sv
// Shared encodings for the pattern generator: pixel modes, FSM states and a
// counter-width helper.
package pattern_pkg;

  typedef enum logic [2:0] {
    MODE_RAMP    = 3'd0,
    MODE_CONST   = 3'd1,
    MODE_ONES    = 3'd2,
    MODE_COUNT   = 3'd3,
    MODE_CHECKER = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LINE  = 2'd2
  } state_e;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_generator_param_if.sv
// Sync/config/pixel bundle between the sync source, the generator and the sink.
//   master : sync source / pixel sink side (drives sync and configuration)
//   slave  : generator side (drives the registered pixel stream and markers)
interface pattern_generator_param_if #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned DELTA_W = 2
);
  logic               f_sync;
  logic               sync;
  logic [2:0]         mode;
  logic [DATA_W-1:0]  const_val;
  logic [DELTA_W-1:0] x_delta;
  logic [DELTA_W-1:0] y_delta;
  logic               gray_en;
  logic [DATA_W-1:0]  pix_out;
  logic               valid;
  logic               sol;
  logic               eol;
  logic               eof;
  logic               busy;

  modport master (
    output f_sync, sync, mode, const_val, x_delta, y_delta, gray_en,
    input  pix_out, valid, sol, eol, eof, busy
  );

  modport slave (
    input  f_sync, sync, mode, const_val, x_delta, y_delta, gray_en,
    output pix_out, valid, sol, eol, eof, busy
  );
endinterface

// File: rtl/pattern_generator_param_gray.sv
// Combinational binary-to-Gray converter placed in front of the pixel register.
//   bin    : binary value
//   gray_c : Gray-coded value (combinational)
module gray_encode #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray_c
);
  assign gray_c = bin ^ (bin >> 1);
endmodule

// File: rtl/pattern_generator_param.sv
// Frame pattern generator: one pixel per clock over LINES x LINE_LEN pixels.
// f_sync arms a frame and captures the configuration, sync starts each line.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of the sync/config/pixel bundle; all outputs registered
module pattern_generator_param
  import pattern_pkg::*;
#(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned LINE_LEN = 4096,
  parameter int unsigned LINES    = 32,
  parameter int unsigned DELTA_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pattern_generator_param_if.slave bus
);

  localparam int unsigned        PIX_W     = clog2_min1(LINE_LEN);
  localparam int unsigned        LINE_W    = clog2_min1(LINES);
  localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(LINE_LEN - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(LINES - 1);

  state_e              state;
  logic [PIX_W-1:0]    pix_idx;     // index of the next pixel to emit in LINE
  logic [LINE_W-1:0]   line_idx;
  logic [DATA_W-1:0]   line_base;
  logic [DATA_W-1:0]   frame_cnt;

  logic [2:0]          cfg_mode;
  logic [DATA_W-1:0]   cfg_const;
  logic [DELTA_W-1:0]  cfg_x;
  logic [DELTA_W-1:0]  cfg_y;
  logic                cfg_gray;

  logic [DATA_W-1:0]   pix_q;
  logic                valid_q;
  logic                sol_q;
  logic                eol_q;
  logic                eof_q;
  logic                busy_q;

  logic                start_c;
  logic                emit_c;
  logic [PIX_W-1:0]    cur_idx_c;
  logic                px_bit_c;
  logic                ln_bit_c;
  logic [DATA_W-1:0]   bin_c;
  logic [DATA_W-1:0]   gray_c;
  logic [DATA_W-1:0]   pix_c;

  // Line start / pixel emission qualifiers; f_sync overrides everything.
  always_comb begin
    start_c   = (state == ARMED) && bus.sync && !bus.f_sync;
    emit_c    = start_c || ((state == LINE) && !bus.f_sync);
    cur_idx_c = start_c ? '0 : pix_idx;
  end

  // Pixel value for the pixel being emitted this cycle.
  always_comb begin
    px_bit_c = 1'(cur_idx_c >> cfg_x);
    ln_bit_c = 1'(line_idx >> cfg_y);
    bin_c    = '0;
    case (cfg_mode)
      MODE_RAMP:    bin_c = line_base + DATA_W'(cur_idx_c) * DATA_W'(cfg_x);
      MODE_CONST:   bin_c = cfg_const;
      MODE_ONES:    bin_c = '1;
      MODE_COUNT:   bin_c = frame_cnt;
      MODE_CHECKER: bin_c = (px_bit_c ^ ln_bit_c) ? '1 : '0;
      default:      bin_c = '0;
    endcase
  end

  gray_encode #(.W(DATA_W)) u_gray (
    .bin    (bin_c),
    .gray_c (gray_c)
  );

  assign pix_c = cfg_gray ? gray_c : bin_c;

  // FSM, counters, configuration capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_idx   <= '0;
      line_idx  <= '0;
      line_base <= '0;
      frame_cnt <= '0;
      cfg_mode  <= '0;
      cfg_const <= '0;
      cfg_x     <= '0;
      cfg_y     <= '0;
      cfg_gray  <= 1'b0;
      pix_q     <= '0;
      valid_q   <= 1'b0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pix_q   <= '0;
      valid_q <= 1'b0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;

      if (bus.f_sync) begin
        // Abort/arm: restart the frame with fresh configuration.
        state     <= ARMED;
        pix_idx   <= '0;
        line_idx  <= '0;
        line_base <= '0;
        frame_cnt <= '0;
        cfg_mode  <= bus.mode;
        cfg_const <= bus.const_val;
        cfg_x     <= bus.x_delta;
        cfg_y     <= bus.y_delta;
        cfg_gray  <= bus.gray_en;
        busy_q    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy_q <= 1'b0;
          end
          ARMED: begin
            busy_q <= 1'b1;
            if (bus.sync) begin
              state   <= LINE;
              pix_idx <= PIX_W'(1);
            end
          end
          LINE: begin
            busy_q <= 1'b1;
            if (pix_idx == PIX_LAST) begin
              eol_q     <= 1'b1;
              pix_idx   <= '0;
              line_idx  <= line_idx + LINE_W'(1);
              line_base <= line_base + DATA_W'(cfg_y);
              if (line_idx == LINE_LAST) begin
                state <= IDLE;
                eof_q <= 1'b1;
              end else begin
                state <= ARMED;
              end
            end else begin
              pix_idx <= pix_idx + PIX_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase

        sol_q <= start_c;
        if (emit_c) begin
          valid_q   <= 1'b1;
          pix_q     <= pix_c;
          frame_cnt <= frame_cnt + DATA_W'(1);
        end
      end
    end
  end

  assign bus.pix_out = pix_q;
  assign bus.valid   = valid_q;
  assign bus.sol     = sol_q;
  assign bus.eol     = eol_q;
  assign bus.eof     = eof_q;
  assign bus.busy    = busy_q;

endmodule

// File: doc/pattern_generator_param.md
# pattern_generator_param

Parametrised next-generation frame pattern generator. It produces one pixel per clock over a frame of `LINES` lines × `LINE_LEN` pixels. Each frame is armed by `f_sync` and each line is started by `sync`. Pixel width and frame geometry are parameters; a checkerboard mode and per-pixel valid/line/frame markers are added. It sits between the sync source and the pixel sink, replacing the fixed 12-bit, fixed-geometry generator top.

## Interface
- `DATA_W`, 12, pixel width; ≥ 2
- `LINE_LEN`, 4096, pixels per line; ≥ 2
- `LINES`, 32, lines per frame; ≥ 1
- `DELTA_W`, 2, width of the x/y delta inputs
- `clk`  in  1  master clock
- `rst`  in  1  asynchronous, active-high reset
- `f_sync`  in  1  frame-arm pulse; samples the configuration inputs
- `sync`  in  1  line-start pulse
- `mode`  in  3  0 RAMP, 1 CONST, 2 ONES, 3 COUNT, 4 CHECKER, 5–7 reserved
- `const_val`  in  DATA_W  constant for CONST mode
- `x_delta`  in  DELTA_W  per-pixel ramp step / checker x-shift
- `y_delta`  in  DELTA_W  per-line ramp step / checker y-shift
- `gray_en`  in  1  1 = Gray-coded output, 0 = binary
- `pix_out`  out  DATA_W  registered pixel
- `valid`  out  1  pix_out is a frame pixel
- `sol`  out  1  first pixel of a line
- `eol`  out  1  last pixel of a line
- `eof`  out  1  last pixel of the frame
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, ARMED, LINE.
  - IDLE: `f_sync` → ARMED.
  - ARMED: `sync` → LINE.
  - LINE: after `LINE_LEN` pixels, → ARMED if `line_idx < LINES-1`, otherwise → IDLE.
- Internal counters:
  - `pix_idx` is `$clog2(LINE_LEN)` bits wide; cleared at the start of each line.
  - `line_idx` is `$clog2(LINES)` bits wide (minimum 1); cleared on `f_sync`.
- `mode`, `const_val`, `x_delta`, `y_delta` and `gray_en` are captured on `f_sync` and held for the whole frame. Mid-frame input changes are ignored.
- All arithmetic is modulo 2^DATA_W; wrap-around is silent. Deltas are zero-extended.
- Pixel value by mode:
  - RAMP: `line_base + pix_idx*x_delta`. `line_base` clears on `f_sync` and adds `y_delta` after each line's eol.
  - CONST: `const_val`.
  - ONES: all ones.
  - COUNT: frame counter. It clears on `f_sync` and increments by 1 per valid pixel across line boundaries, holding its value between lines.
  - CHECKER: all ones if bit0 of `(pix_idx >> x_delta) ^ (line_idx >> y_delta)` is 1, otherwise 0.
  - Reserved modes: 0.
- Gray coding: when the captured `gray_en` = 1, `pix_out` = `b ^ (b >> 1)` of the binary value.
- Event priority and boundaries:
  - `f_sync` in any state aborts the frame, clears all counters, recaptures the configuration and goes to ARMED. Outputs drop next cycle with no eol/eof.
  - `f_sync` and `sync` in the same cycle: `f_sync` wins and `sync` is dropped.
  - `sync` in IDLE or LINE is ignored.
  - A zero delta gives a flat ramp; this is legal.
- Reset (async assert, sync release): state IDLE, all counters and captured configuration 0. `pix_out`, `valid`, `sol`, `eol`, `eof` and `busy` are all 0.

## Timing
- `sync` sampled high in ARMED at edge n → `valid` and `sol` high in cycle n+1, with the pixel for `pix_idx` = 0.
- `valid` stays high for exactly `LINE_LEN` consecutive cycles.
- `eol` coincides with the last valid pixel of each line. `eof` coincides with `eol` of line `LINES-1`.
- `sol` and `eol` are never both high, because `LINE_LEN` ≥ 2.
- The earliest accepted next `sync` is the cycle after `eol`, which gives back-to-back lines with no gap.
- `busy` rises the cycle after `f_sync` and falls the cycle after `eof`.
- All outputs are registered: 1-cycle latency, no combinational input-to-output path.

## Structure
- Shared package `pattern_pkg`: mode encodings (`MODE_RAMP`…`MODE_CHECKER`) and state encoding (IDLE/ARMED/LINE).
- One sub-module, `gray_encode #(W)`: a combinational binary→Gray converter, instantiated in front of the output register.
- The top module holds the FSM, counters, configuration capture and pixel mux.

## Test plan
- Reset, then defaults with RAMP, x=1, y=2, `f_sync` then `sync` at cycle 10 → pixels 0..4095 at cycles 11..4106, `sol`@11, `eol`@4106. Second line starts at 2.
- `LINE_LEN`=8, `LINES`=2, COUNT, two syncs → pixels 0..7 then 8..15. `eof` on value 15, `busy` falls next cycle. A further `sync` is ignored.
- CONST 0xA5A, `gray_en`=1 → `pix_out` = 0xF77 on every valid cycle. Changing `const_val` mid-frame has no effect.
- CHECKER, x=1, y=0, `LINE_LEN`=8 → line 0 reads 0,0,FFF,FFF,0,0,FFF,FFF; line 1 is inverted.
- `f_sync` mid-line at pixel 3 → `valid` low next cycle, no `eol`. A later `sync` restarts at `pix_idx` 0 with `line_idx` 0.
- `f_sync`+`sync` in the same cycle, and `rst` asserted mid-line → the FSM waits in ARMED for the former; the latter drives all outputs to 0 asynchronously.
